// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard handshake between the decode pipeline (master) and the
// load-use hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_mem_read;
    logic              flush;
    logic              mem_busy;
    logic              stall;
    logic              ctrl_bubble;
    logic [1:0]        haz_state;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_mem_read, flush, mem_busy,
        input  stall, ctrl_bubble, haz_state, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_mem_read, flush, mem_busy,
        output stall, ctrl_bubble, haz_state, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: LOAD_LAT in-flight load tags, stall/bubble
// generation and a RUN/LOAD_STALL/MEM_FREEZE state. Optional stall counter
// is built only when HAZ_STALL_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input logic            clk,
    input logic            rst_n,
    hazard_scoreboard_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_FREEZE = 2'd2
    } haz_state_e;

    haz_state_e                     state_r;
    haz_state_e                     next_state_s;
    logic [LOAD_LAT-1:0]            slot_valid_r;
    logic [LOAD_LAT-1:0][REG_AW-1:0] slot_rd_r;
    logic                           hit_s;
    logic                           push_s;
    logic                           stall_s;

    // x0 is hard-wired zero, so it can never be the subject of a hazard
    function automatic logic src_match(input logic              used,
                                       input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] tag);
        return used && (src != {REG_AW{1'b0}}) && (src == tag);
    endfunction

    // Compare both ID sources against every live load tag
    always_comb begin
        hit_s = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            hit_s = hit_s | (bus.id_valid & slot_valid_r[k] &
                             (src_match(bus.id_rs1_used, bus.id_rs1, slot_rd_r[k]) |
                              src_match(bus.id_rs2_used, bus.id_rs2, slot_rd_r[k])));
        end
    end

    // A stalled or flushed instruction must not leave a tag behind
    always_comb begin
        push_s = bus.id_valid & bus.id_mem_read & (bus.id_rd != {REG_AW{1'b0}}) &
                 ~hit_s & ~bus.flush;
    end

    // Memory freeze dominates; a pending hit is re-evaluated once it releases
    always_comb begin
        if (bus.mem_busy) begin
            next_state_s = ST_MEM_FREEZE;
        end else if (hit_s) begin
            next_state_s = ST_LOAD_STALL;
        end else begin
            next_state_s = ST_RUN;
        end
    end

    // Tag slots advance one stage per unfrozen cycle; a hit shifts in a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= '0;
            slot_rd_r    <= '0;
        end else if (!bus.mem_busy) begin
            for (int k = LOAD_LAT - 1; k > 0; k--) begin
                slot_valid_r[k] <= slot_valid_r[k-1];
                slot_rd_r[k]    <= slot_rd_r[k-1];
            end
            slot_valid_r[0] <= push_s;
            slot_rd_r[0]    <= bus.id_rd;
        end else begin
            slot_valid_r <= slot_valid_r;
            slot_rd_r    <= slot_rd_r;
        end
    end

    // State register; any corrupted encoding falls back to RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN, ST_LOAD_STALL, ST_MEM_FREEZE: state_r <= next_state_s;
                default:                              state_r <= ST_RUN;
            endcase
        end
    end

    assign stall_s         = bus.mem_busy | hit_s;
    assign bus.stall       = stall_s;
    assign bus.ctrl_bubble = hit_s & ~bus.mem_busy;
    assign bus.haz_state   = state_r;

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating count of every stalled cycle, freeze cycles included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (LOAD_LAT=3, CNT_W=4): directed
// load-use scenarios plus random traffic against a timestamp-based model.
module tb_hazard_scoreboard;

    localparam int LAT     = 3;
    localparam int AW      = 5;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total  = 0;
    int   passed = 0;
    logic last_bubble;

    hazard_scoreboard_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    hazard_scoreboard #(.REG_AW(AW), .LOAD_LAT(LAT), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: every load remembers how many pipeline advances had happened
    // when it left ID; it is dangerous while 1..LAT advances have elapsed.
    typedef struct {
        logic [AW-1:0] rd;
        int            born;
    } ld_t;

    ld_t inflight[$];
    int  adv       = 0;
    int  exp_state = 0;
    int  exp_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic reads(input logic used, input logic [AW-1:0] src, input logic [AW-1:0] rd);
        return used && (src != 5'd0) && (src == rd);
    endfunction

    function automatic logic model_hit();
        logic h;
        h = 1'b0;
        if (bus.id_valid) begin
            foreach (inflight[i]) begin
                if ((adv - inflight[i].born) <= LAT &&
                    (reads(bus.id_rs1_used, bus.id_rs1, inflight[i].rd) ||
                     reads(bus.id_rs2_used, bus.id_rs2, inflight[i].rd)))
                    h = 1'b1;
            end
        end
        return h;
    endfunction

    task automatic model_clock(input logic h);
        logic st;
        st = bus.mem_busy | h;
        exp_state = bus.mem_busy ? 2 : (h ? 1 : 0);
`ifdef HAZ_STALL_CNT_EN
        if (st && exp_cnt < CNT_MAX) exp_cnt++;
`endif
        if (!bus.mem_busy) begin
            if (bus.id_valid && bus.id_mem_read && bus.id_rd != 5'd0 && !h && !bus.flush)
                inflight.push_back('{rd: bus.id_rd, born: adv});
            adv++;
            while (inflight.size() > 0 && (adv - inflight[0].born) > LAT)
                void'(inflight.pop_front());
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        adv = 0;
        exp_state = 0;
        exp_cnt = 0;
    endtask

    task automatic idle_inputs();
        bus.id_valid = 1'b0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0; bus.id_rd = 5'd0;
        bus.id_mem_read = 1'b0; bus.flush = 1'b0; bus.mem_busy = 1'b0;
    endtask

    // Entered at posedge+1 with inputs driven; leaves at the next posedge+1
    task automatic step();
        logic h;
        #3;
        h = model_hit();
        check("stall", bus.stall, bus.mem_busy | h);
        check("ctrl_bubble", bus.ctrl_bubble, h & ~bus.mem_busy);
        check("haz_state", bus.haz_state, exp_state);
        check("stall_cnt", bus.stall_cnt, exp_cnt);
        last_bubble = bus.ctrl_bubble;
        @(posedge clk);
        model_clock(h);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check("rst_stall", bus.stall, 1'b0);
        check("rst_bubble", bus.ctrl_bubble, 1'b0);
        check("rst_state", bus.haz_state, 2'd0);
        check("rst_cnt", bus.stall_cnt, 4'd0);
        bus.mem_busy = 1'b1;
        #1;
        check("rst_busy_stall", bus.stall, 1'b1);
        check("rst_busy_bubble", bus.ctrl_bubble, 1'b0);
        bus.mem_busy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Hold one instruction in ID until it advances; count DUT bubble cycles
    task automatic issue(input logic rs1u, input logic [AW-1:0] rs1,
                         input logic rs2u, input logic [AW-1:0] rs2,
                         input logic ld, input logic [AW-1:0] rd,
                         input int busy_cycles, output int bubbles);
        int   cyc;
        logic held;
        bus.id_valid = 1'b1; bus.id_rs1_used = rs1u; bus.id_rs1 = rs1;
        bus.id_rs2_used = rs2u; bus.id_rs2 = rs2; bus.id_mem_read = ld;
        bus.id_rd = rd; bus.flush = 1'b0;
        bubbles = 0;
        cyc = 0;
        do begin
            bus.mem_busy = (cyc < busy_cycles);
            held = model_hit() | bus.mem_busy;
            step();
            if (last_bubble) bubbles++;
            cyc++;
        end while (held && cyc < 40);
        if (cyc >= 40) check("issue_timeout", cyc, 0);
        idle_inputs();
    endtask

    initial begin
        int nb;
        idle_inputs();
        do_reset();

        // distance 2 at LOAD_LAT=3 -> 2 stalls
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 0, nb);
        check("load_no_stall", nb, 0);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 0, nb);
        issue(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd2, 0, nb);
        check("dist2_bubbles", nb, 2);

        // distance 4 -> out of reach
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 0, nb);
        for (int i = 0; i < 3; i++) issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 0, nb);
        issue(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd2, 0, nb);
        check("dist4_bubbles", nb, 0);

        // distance 1 -> LOAD_LAT stalls
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 0, nb);
        issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd3, 0, nb);
        check("dist1_bubbles", nb, 3);

        // x0 load and use never stall
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 0, nb);
        issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 0, nb);
        check("x0_bubbles", nb, 0);

        // freeze for 3 cycles on top of a pending hazard, then full stall
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 0, nb);
        issue(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd3, 3, nb);
        check("freeze_bubbles", nb, 3);

        // flushed load pushes no tag
        bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_rd = 5'd6; bus.flush = 1'b1;
        step();
        idle_inputs();
        issue(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd3, 0, nb);
        check("flush_bubbles", nb, 0);

        // flush together with a hit still stalls
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 0, nb);
        bus.id_valid = 1'b1; bus.id_rs1_used = 1'b1; bus.id_rs1 = 5'd4;
        bus.id_mem_read = 1'b1; bus.id_rd = 5'd6; bus.flush = 1'b1;
        step();
        check("flush_hit_bubble", last_bubble, 1'b1);
        idle_inputs();
        issue(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd3, 0, nb);
        check("flush_hit_no_tag", nb, 0);

        // reset pulsed in the middle of a load stall
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 0, nb);
        bus.id_valid = 1'b1; bus.id_rs1_used = 1'b1; bus.id_rs1 = 5'd3;
        step();
        #2;
        check("pre_rst_stall", bus.stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", bus.stall, 1'b0);
        check("mid_rst_bubble", bus.ctrl_bubble, 1'b0);
        check("mid_rst_state", bus.haz_state, 2'd0);
        check("mid_rst_cnt", bus.stall_cnt, 4'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_bubble", last_bubble, 1'b0);
        idle_inputs();

        // random traffic over a small register set to provoke hits
        for (int i = 0; i < 400; i++) begin
            bus.id_valid    = ($urandom_range(0, 9) < 8);
            bus.id_rs1      = 5'($urandom_range(0, 3));
            bus.id_rs2      = 5'($urandom_range(0, 3));
            bus.id_rs1_used = 1'($urandom_range(0, 1));
            bus.id_rs2_used = 1'($urandom_range(0, 1));
            bus.id_rd       = 5'($urandom_range(0, 3));
            bus.id_mem_read = ($urandom_range(0, 2) == 0);
            bus.flush       = ($urandom_range(0, 7) == 0);
            bus.mem_busy    = ($urandom_range(0, 3) == 0);
            step();
        end
        idle_inputs();

        // counter saturation over 20 frozen cycles
        do_reset();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) step();
        bus.mem_busy = 1'b0;
`ifdef HAZ_STALL_CNT_EN
        check("cnt_saturated", bus.stall_cnt, 4'd15);
`else
        check("cnt_tied_zero", bus.stall_cnt, 4'd0);
`endif
        check("state_after_freeze", bus.haz_state, 2'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5, register-index width.
REQ-002 Parameter LOAD_LAT, default 1, legal 1..4; number of load-use stall cycles (tag slots).
REQ-003 Parameter CNT_W, default 32, stall-counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 id_valid  input  1  ID-stage instruction valid.
REQ-007 id_rs1, id_rs2  input  REG_AW each  ID source indices.
REQ-008 id_rs1_used, id_rs2_used  input  1 each  source actually read.
REQ-009 id_rd  input  REG_AW  ID destination index.
REQ-010 id_mem_read  input  1  ID instruction is a load.
REQ-011 flush  input  1  kill ID-stage instruction this cycle.
REQ-012 mem_busy  input  1  data memory not ready; whole pipe must freeze.
REQ-013 stall  output  1  hold PC and IF/ID (combinational).
REQ-014 ctrl_bubble  output  1  zero ID/EX control this cycle (combinational).
REQ-015 haz_state  output  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 MEM_FREEZE.
REQ-016 stall_cnt  output  CNT_W  stall-cycle count (REQ-033).

Function
REQ-017 Block SHALL hold LOAD_LAT tag slots, each {valid, rd}; slot k is a load k+1 stages younger-side past ID.
REQ-018 hit SHALL be 1 when id_valid and, for rs1 or rs2, used=1, index!=0, and equals rd of any valid slot.
REQ-019 stall SHALL equal mem_busy OR hit; ctrl_bubble SHALL equal hit AND NOT mem_busy.
REQ-020 mem_busy=1: slots and haz_state-independent contents SHALL hold unchanged (freeze).
REQ-021 mem_busy=0: slots SHALL shift k->k+1, last slot discarded.
REQ-022 Shift input to slot 0: valid=id_valid AND id_mem_read AND id_rd!=0 AND NOT hit AND NOT flush; rd=id_rd.
REQ-023 Load-use distance d (1..LOAD_LAT) SHALL produce exactly LOAD_LAT-d+1 stall cycles, absent mem_busy.
REQ-024 Register x0 SHALL never create or match a hazard.
REQ-025 flush with hit SHALL still assert stall that cycle; no tag pushed.
REQ-026 FSM next state: mem_busy -> MEM_FREEZE; else hit -> LOAD_STALL; else RUN; registered, reflecting previous cycle's condition.
REQ-027 haz_state SHALL never take value 3; illegal encoding SHALL recover to RUN next cycle.
REQ-028 Simultaneous mem_busy and hit: MEM_FREEZE wins; hit re-evaluated after freeze releases.

Reset
REQ-029 rst_n low SHALL asynchronously clear all slot valids, rd fields to 0, haz_state to RUN, stall_cnt to 0.
REQ-030 During reset, stall and ctrl_bubble SHALL be 0 unless mem_busy=1 (stall only).
REQ-031 Reset asserted mid-stall SHALL drop stall next evaluation; no stale tag survives.
REQ-032 Reset release SHALL be synchronous-safe: first edge after release performs normal update.

Configuration
REQ-033 Macro HAZ_STALL_CNT_EN defined: stall_cnt increments by 1 each cycle stall=1, saturating at all-ones.
REQ-034 Macro HAZ_STALL_CNT_EN undefined: counter logic absent; stall_cnt SHALL be tied to 0.

Verification
REQ-035 LOAD_LAT=1: load rd=5, next ID rs1=5 used -> stall=1, ctrl_bubble=1 one cycle, then 0, haz_state 1 then 0.
REQ-036 LOAD_LAT=3: load rd=7, instruction at distance 2 rs2=7 -> stall exactly 2 cycles; distance 4 -> no stall.
REQ-037 Load rd=0 followed by rs1=0 use -> stall never asserts.
REQ-038 Hazard pending, mem_busy=1 for 3 cycles -> stall=1, ctrl_bubble=0, haz_state=2, slots frozen; after release, remaining load stall still occurs.
REQ-039 rst_n pulsed low mid-LOAD_STALL -> stall=0, haz_state=0, stall_cnt=0 immediately, no hazard after release.
REQ-040 HAZ_STALL_CNT_EN, CNT_W=4, 20 stall cycles -> stall_cnt=15 saturated; undefined -> stall_cnt=0.
